// File: rtl/run_detect_word_scheduler.sv
// Word-to-serial scheduler for an identical-run detector: shifts each accepted word out MSB first,
// tracks run history across words, and returns a per-word hit count and polarity flags.
module run_detect_word_scheduler #(
  parameter int WORD_W  = 8,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 4
) (
  input  logic              pCLK,
  input  logic              pREST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_clr,
  output logic              det_w,
  output logic              det_en,
  output logic              det_hit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [1:0]        out_flags
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t             stateReg, stateNext;
  logic [WORD_W-1:0]  wordReg, wordNext;
  logic [IDX_W-1:0]   idxReg, idxNext;
  logic [RUN_W-1:0]   runCntReg, runCntNext, runCntUpd;
  logic               runBitReg, runBitNext;
  logic [CNT_W-1:0]   countReg, countNext;
  logic [1:0]         flagsReg, flagsNext;

  always_ff @(posedge pCLK) begin
    if (pREST) begin
      stateReg  <= IDLE;
      wordReg   <= '0;
      idxReg    <= '0;
      runCntReg <= '0;
      runBitReg <= 1'b0;
      countReg  <= '0;
      flagsReg  <= '0;
    end else begin
      stateReg  <= stateNext;
      wordReg   <= wordNext;
      idxReg    <= idxNext;
      runCntReg <= runCntNext;
      runBitReg <= runBitNext;
      countReg  <= countNext;
      flagsReg  <= flagsNext;
    end
  end

  assign in_ready  = (stateReg == IDLE);
  assign det_en    = (stateReg == SHIFT);
  assign det_w     = det_en ? wordReg[idxReg] : 1'b0;
  assign out_valid = (stateReg == REPORT);
  assign out_count = countReg;
  assign out_flags = flagsReg;

  // Run length as it stands after the current bit; clamped so a long run keeps reporting hits.
  always_comb begin
    runCntUpd = RUN_W'(1);
    if (runCntReg != '0 && det_w == runBitReg) begin
      runCntUpd = (runCntReg == RUN_MAX) ? RUN_MAX : runCntReg + 1'b1;
    end
  end

  assign det_hit = det_en && (runCntUpd == RUN_MAX);

  always_comb begin
    stateNext  = stateReg;
    wordNext   = wordReg;
    idxNext    = idxReg;
    runCntNext = runCntReg;
    runBitNext = runBitReg;
    countNext  = countReg;
    flagsNext  = flagsReg;
    case (stateReg)
      IDLE: begin
        if (in_valid) begin
          wordNext  = in_data;
          countNext = '0;
          flagsNext = '0;
          idxNext   = IDX_TOP;
          stateNext = SHIFT;
          if (in_clr) runCntNext = '0;
        end
      end
      SHIFT: begin
        runBitNext = det_w;
        runCntNext = runCntUpd;
        if (det_hit) begin
          if (countReg != CNT_MAX) countNext = countReg + 1'b1;
          flagsNext[det_w] = 1'b1;
        end
        if (idxReg == '0) stateNext = REPORT;
        else              idxNext   = idxReg - 1'b1;
      end
      REPORT: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_detect_word_scheduler.sv
// Randomised bench for run_detect_word_scheduler: a run-length reference model checks the serial stream
// and reports of a default instance and a narrow-counter instance driven with identical stimulus.
module tb_run_detect_word_scheduler;
  localparam int WORD_W  = 8;
  localparam int RUN_LEN = 4;
  localparam int CNT_W   = 4;
  localparam int SAT_W   = 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_clr, out_ready;
  logic [WORD_W-1:0] in_data;

  logic a_in_ready, a_det_w, a_det_en, a_det_hit, a_out_valid;
  logic [CNT_W-1:0] a_out_count;
  logic [1:0] a_out_flags;
  logic s_in_ready, s_det_w, s_det_en, s_det_hit, s_out_valid;
  logic [SAT_W-1:0] s_out_count;
  logic [1:0] s_out_flags;

  int nTests = 0;
  int nFail  = 0;
  int cycle  = 0;

  // reference run history: length of the current identical run (unbounded) and its bit value
  int mLen = 0;
  bit mBit = 1'b0;

  run_detect_word_scheduler #(.WORD_W(WORD_W), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .pCLK(clk), .pREST(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_clr(in_clr), .det_w(a_det_w), .det_en(a_det_en), .det_hit(a_det_hit),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_count(a_out_count), .out_flags(a_out_flags));

  run_detect_word_scheduler #(.WORD_W(WORD_W), .RUN_LEN(RUN_LEN), .CNT_W(SAT_W)) dutSat (
    .pCLK(clk), .pREST(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_clr(in_clr), .det_w(s_det_w), .det_en(s_det_en), .det_hit(s_det_hit),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_count(s_out_count), .out_flags(s_out_flags));

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #500000;
    $display("FAIL global_timeout cycle=%0d", cycle);
    $fatal(1, "timeout");
  end

  function automatic int satv(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word, checks every serial bit and the report; stall = REPORT cycles with out_ready low.
  task automatic send_word(input logic [WORD_W-1:0] d, input bit clr, input int stall, output int acceptCycle);
    int hits, waitN;
    logic [1:0] flags;
    logic [CNT_W-1:0] expA;
    logic [SAT_W-1:0] expS;
    logic [CNT_W-1:0] heldA;
    logic [1:0] heldF;
    bit b, expHit;
    waitN = 0;
    while (a_in_ready !== 1'b1 && waitN < 20) begin
      step();
      waitN++;
    end
    nTests++;
    if (a_in_ready !== 1'b1) begin
      nFail++;
      $display("FAIL accept_wait in_ready=%b required 1", a_in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_clr   = clr;
    step();
    acceptCycle = cycle;
    in_valid = 1'b0;
    in_clr   = 1'b0;
    if (clr) mLen = 0;
    hits  = 0;
    flags = 2'b00;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      b = d[i];
      if (mLen > 0 && b == mBit) mLen++;
      else begin
        mLen = 1;
        mBit = b;
      end
      expHit = (mLen >= RUN_LEN);
      if (expHit) begin
        hits++;
        flags[b] = 1'b1;
      end
      nTests++;
      if (a_det_en !== 1'b1 || a_det_w !== b || a_det_hit !== expHit || a_in_ready !== 1'b0) begin
        nFail++;
        $display("FAIL bit word=%h idx=%0d en/w/hit/rdy=%b%b%b%b required 1%b%b0",
                 d, i, a_det_en, a_det_w, a_det_hit, a_in_ready, b, expHit);
      end
      step();
    end
    expA = CNT_W'(satv(hits, CNT_W));
    expS = SAT_W'(satv(hits, SAT_W));
    heldA = a_out_count;
    heldF = a_out_flags;
    for (int k = 0; k <= stall; k++) begin
      nTests++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_det_en !== 1'b0 || a_det_hit !== 1'b0 ||
          a_out_count !== expA || a_out_flags !== flags) begin
        nFail++;
        $display("FAIL report word=%h k=%0d vld/rdy/en/hit=%b%b%b%b count=%0d flags=%b required 1000 count=%0d flags=%b",
                 d, k, a_out_valid, a_in_ready, a_det_en, a_det_hit, a_out_count, a_out_flags, expA, flags);
      end
      nTests++;
      if (s_out_valid !== 1'b1 || s_out_count !== expS || s_out_flags !== flags) begin
        nFail++;
        $display("FAIL sat_report word=%h vld=%b count=%0d flags=%b required 1 count=%0d flags=%b",
                 d, s_out_valid, s_out_count, s_out_flags, expS, flags);
      end
      if (k > 0) begin
        nTests++;
        if (a_out_count !== heldA || a_out_flags !== heldF) begin
          nFail++;
          $display("FAIL report_hold count=%0d flags=%b required count=%0d flags=%b",
                   a_out_count, a_out_flags, heldA, heldF);
        end
      end
      if (k < stall) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = WORD_W'($urandom);
      end else begin
        out_ready = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    nTests++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_det_en !== 1'b0) begin
      nFail++;
      $display("FAIL return_idle vld/rdy/en=%b%b%b required 010", a_out_valid, a_in_ready, a_det_en);
    end
    $display("[TB] word=%h clr=%0d stall=%0d hits=%0d count=%0d flags=%b", d, clr, stall, hits, a_out_count, a_out_flags);
  endtask

  task automatic check_all_zero(input string tag);
    nTests++;
    if (a_in_ready !== 1'b1 || a_det_w !== 1'b0 || a_det_en !== 1'b0 || a_det_hit !== 1'b0 ||
        a_out_valid !== 1'b0 || a_out_count !== '0 || a_out_flags !== 2'b00) begin
      nFail++;
      $display("FAIL %s rdy=%b w/en/hit=%b%b%b vld=%b count=%0d flags=%b required rdy=1 others 0",
               tag, a_in_ready, a_det_w, a_det_en, a_det_hit, a_out_valid, a_out_count, a_out_flags);
    end
    nTests++;
    if (s_in_ready !== 1'b1 || s_det_en !== 1'b0 || s_out_valid !== 1'b0 || s_out_count !== '0 || s_out_flags !== 2'b00) begin
      nFail++;
      $display("FAIL %s_sat rdy=%b en=%b vld=%b count=%0d flags=%b required rdy=1 others 0",
               tag, s_in_ready, s_det_en, s_out_valid, s_out_count, s_out_flags);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_clr = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    mLen = 0;
    step();
    check_all_zero("post_reset");
  endtask

  task automatic test_directed();
    int t;
    send_word(8'hF0, 1'b1, 0, t);
    send_word(8'hFF, 1'b1, 0, t);
    send_word(8'h03, 1'b1, 0, t);
    send_word(8'hC0, 1'b0, 0, t);
    send_word(8'h03, 1'b1, 0, t);
    send_word(8'hC0, 1'b1, 0, t);
    send_word(8'h00, 1'b1, 0, t);
    send_word(8'h00, 1'b0, 0, t);
  endtask

  task automatic test_stall();
    int t;
    send_word(8'hE1, 1'b1, 5, t);
    send_word(8'h87, 1'b0, 2, t);
  endtask

  task automatic test_reset_mid();
    int t;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    in_clr   = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    mLen = 0;
    check_all_zero("reset_mid");
    send_word(8'h0F, 1'b0, 0, t);
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    send_word(WORD_W'($urandom), 1'b0, 0, t0);
    for (int i = 0; i < 4; i++) begin
      send_word(WORD_W'($urandom), 1'b0, 0, t1);
      nTests++;
      if (t1 - t0 !== WORD_W + 2) begin
        nFail++;
        $display("FAIL throughput spacing=%0d required %0d", t1 - t0, WORD_W + 2);
      end
      t0 = t1;
    end
  endtask

  task automatic test_random();
    int t;
    logic [WORD_W-1:0] d;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = '1;
        default: d = WORD_W'($urandom);
      endcase
      send_word(d, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), t);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
